// File: rtl/pfd_tune_ctrl_pkg.sv
// rtl/pfd_tune_ctrl_pkg.sv - shared types, defaults and decision rule for the pfd tuning controller
package pfd_tune_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COARSE = 2'd1,
    ST_FINE   = 2'd2,
    ST_LOCKED = 2'd3
  } tune_state_e;

  typedef enum logic [1:0] {
    DEC_INBAND = 2'd0,
    DEC_UP     = 2'd1,
    DEC_DOWN   = 2'd2
  } decision_e;

  localparam int CODE_W_DEF     = 8;
  localparam int WIN_DEF        = 32;
  localparam int SETTLE_DEF     = 4;
  localparam int TOL_DEF        = 2;
  localparam int LOCK_CNT_DEF   = 4;
  localparam int UNLOCK_CNT_DEF = 2;

  // fd running fast means the DCO must slow down, and vice versa
  function automatic decision_e decide(input int unsigned fast_cnt,
                                       input int unsigned slow_cnt,
                                       input int unsigned tol);
    if (fast_cnt > slow_cnt + tol) return DEC_DOWN;
    if (slow_cnt > fast_cnt + tol) return DEC_UP;
    return DEC_INBAND;
  endfunction

endpackage

// File: rtl/pfd_win_counter.sv
// rtl/pfd_win_counter.sv - synchronizes pfd indications, sequences settle/measure windows and decides per window
module pfd_win_counter
  import pfd_tune_ctrl_pkg::*;
#(
  parameter int WIN    = WIN_DEF,
  parameter int SETTLE = SETTLE_DEF,
  parameter int TOL    = TOL_DEF
) (
  input  logic      ref_clk,
  input  logic      rst,
  input  logic      restart,
  input  logic      active,
  input  logic      fast,
  input  logic      slow,
  output logic      pfd_clr,
  output logic      win_done,
  output decision_e decision
);

  localparam int PER   = SETTLE + WIN;
  localparam int PH_W  = $clog2(PER);
  localparam int CNT_W = $clog2(WIN + 1);
  localparam logic [PH_W-1:0] SETTLE_P = PH_W'(SETTLE);
  localparam logic [PH_W-1:0] LAST_P   = PH_W'(PER - 1);

  logic [1:0]       fast_sync;
  logic [1:0]       slow_sync;
  logic             fast_s;
  logic             slow_s;
  logic [PH_W-1:0]  phase;
  logic [PH_W-1:0]  phase_nxt;
  logic [CNT_W-1:0] fast_cnt;
  logic [CNT_W-1:0] slow_cnt;
  logic [CNT_W-1:0] fast_nxt;
  logic [CNT_W-1:0] slow_nxt;
  logic             measuring;
  logic             last_cycle;

  // two-flop synchronizers for the asynchronous pfd indications
  always_ff @(posedge ref_clk) begin
    if (rst) begin
      fast_sync <= '0;
      slow_sync <= '0;
    end else begin
      fast_sync <= {fast_sync[0], fast};
      slow_sync <= {slow_sync[0], slow};
    end
  end

  assign fast_s     = fast_sync[1];
  assign slow_s     = slow_sync[1];
  assign measuring  = (phase >= SETTLE_P);
  assign last_cycle = (phase == LAST_P);
  assign phase_nxt  = last_cycle ? '0 : phase + PH_W'(1);
  // the last measure cycle's own sample is folded in before deciding
  assign fast_nxt   = fast_cnt + CNT_W'(fast_s & ~slow_s);
  assign slow_nxt   = slow_cnt + CNT_W'(slow_s & ~fast_s);
  assign win_done   = active & last_cycle;
  assign decision   = decide(32'(fast_nxt), 32'(slow_nxt), TOL);

  // phase sequencing, pfd_clr generation and window accumulation
  always_ff @(posedge ref_clk) begin
    if (rst) begin
      phase    <= '0;
      pfd_clr  <= 1'b0;
      fast_cnt <= '0;
      slow_cnt <= '0;
    end else if (restart) begin
      phase    <= '0;
      pfd_clr  <= 1'b1;
      fast_cnt <= '0;
      slow_cnt <= '0;
    end else if (active) begin
      phase   <= phase_nxt;
      pfd_clr <= (phase_nxt < SETTLE_P);
      if (measuring && !last_cycle) begin
        fast_cnt <= fast_nxt;
        slow_cnt <= slow_nxt;
      end else begin
        fast_cnt <= '0;
        slow_cnt <= '0;
      end
    end else begin
      phase    <= '0;
      pfd_clr  <= 1'b0;
      fast_cnt <= '0;
      slow_cnt <= '0;
    end
  end

endmodule

// File: rtl/pfd_tune_ctrl.sv
// rtl/pfd_tune_ctrl.sv - closed-loop DCO tuning: coarse binary search, fine tracking, lock/unlock detection
module pfd_tune_ctrl
  import pfd_tune_ctrl_pkg::*;
#(
  parameter int CODE_W     = CODE_W_DEF,
  parameter int WIN        = WIN_DEF,
  parameter int SETTLE     = SETTLE_DEF,
  parameter int TOL        = TOL_DEF,
  parameter int LOCK_CNT   = LOCK_CNT_DEF,
  parameter int UNLOCK_CNT = UNLOCK_CNT_DEF
) (
  input  logic              ref_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              fast,
  input  logic              slow,
  output logic [CODE_W-1:0] dco_code,
  output logic              pfd_clr,
  output logic              busy,
  output logic              locked,
  output logic              sat
);

  localparam int IB_W  = $clog2(LOCK_CNT + 1);
  localparam int OOB_W = $clog2(UNLOCK_CNT + 1);
  localparam logic [CODE_W-1:0] CODE_MID  = CODE_W'(1) << (CODE_W - 1);
  localparam logic [CODE_W-1:0] STEP_INIT = CODE_W'(1) << (CODE_W - 2);
  localparam logic [CODE_W-1:0] CODE_MAX  = '1;
  localparam logic [IB_W-1:0]   LOCK_P    = IB_W'(LOCK_CNT);
  localparam logic [OOB_W-1:0]  UNLOCK_P  = OOB_W'(UNLOCK_CNT);

  tune_state_e       state;
  logic [CODE_W-1:0] step;
  logic [IB_W-1:0]   inband_cnt;
  logic [IB_W-1:0]   inband_nxt;
  logic [OOB_W-1:0]  oob_cnt;
  logic [OOB_W-1:0]  oob_nxt;
  logic              win_done;
  decision_e         decision;
  logic              restart;
  logic [CODE_W-1:0] fine_code;
  logic              fine_clip;

  assign restart    = start & (state == ST_IDLE);
  assign inband_nxt = inband_cnt + IB_W'(1);
  assign oob_nxt    = oob_cnt + OOB_W'(1);

  pfd_win_counter #(
    .WIN    (WIN),
    .SETTLE (SETTLE),
    .TOL    (TOL)
  ) u_win (
    .ref_clk  (ref_clk),
    .rst      (rst),
    .restart  (restart),
    .active   (busy),
    .fast     (fast),
    .slow     (slow),
    .pfd_clr  (pfd_clr),
    .win_done (win_done),
    .decision (decision)
  );

  // saturating +/-1 step used by fine tracking and by the unlock window
  always_comb begin
    fine_code = dco_code;
    fine_clip = 1'b0;
    if (decision == DEC_UP) begin
      if (dco_code == CODE_MAX) fine_clip = 1'b1;
      else                      fine_code = dco_code + CODE_W'(1);
    end else if (decision == DEC_DOWN) begin
      if (dco_code == '0) fine_clip = 1'b1;
      else                fine_code = dco_code - CODE_W'(1);
    end
  end

  // tuning state machine, advanced once per completed window
  always_ff @(posedge ref_clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      dco_code   <= CODE_MID;
      step       <= STEP_INIT;
      inband_cnt <= '0;
      oob_cnt    <= '0;
      busy       <= 1'b0;
      locked     <= 1'b0;
      sat        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_COARSE;
            busy       <= 1'b1;
            dco_code   <= CODE_MID;
            step       <= STEP_INIT;
            sat        <= 1'b0;
            inband_cnt <= '0;
            oob_cnt    <= '0;
          end
        end
        ST_COARSE: begin
          if (win_done) begin
            if (decision == DEC_INBAND) begin
              state <= ST_FINE;
            end else begin
              dco_code <= (decision == DEC_UP) ? dco_code + step : dco_code - step;
              step     <= step >> 1;
              if (step == CODE_W'(1)) state <= ST_FINE;
            end
          end
        end
        ST_FINE: begin
          if (win_done) begin
            if (decision == DEC_INBAND) begin
              sat <= 1'b0;
              if (inband_nxt == LOCK_P) begin
                state      <= ST_LOCKED;
                locked     <= 1'b1;
                inband_cnt <= '0;
                oob_cnt    <= '0;
              end else begin
                inband_cnt <= inband_nxt;
              end
            end else begin
              dco_code   <= fine_code;
              sat        <= fine_clip;
              inband_cnt <= '0;
            end
          end
        end
        ST_LOCKED: begin
          if (win_done) begin
            if (decision == DEC_INBAND) begin
              oob_cnt <= '0;
            end else if (oob_nxt == UNLOCK_P) begin
              state      <= ST_FINE;
              locked     <= 1'b0;
              oob_cnt    <= '0;
              inband_cnt <= '0;
              dco_code   <= fine_code;
              sat        <= fine_clip;
            end else begin
              oob_cnt <= oob_nxt;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pfd_tune_ctrl.sv
// tb/tb_pfd_tune_ctrl.sv - self-checking bench for pfd_tune_ctrl against a window-level reference model
module tb_pfd_tune_ctrl;

  localparam int CODE_W     = 8;
  localparam int WIN        = 32;
  localparam int SETTLE     = 4;
  localparam int TOL        = 2;
  localparam int LOCK_CNT   = 4;
  localparam int UNLOCK_CNT = 2;
  localparam int PER        = SETTLE + WIN;
  localparam int CODE_MAX   = (1 << CODE_W) - 1;

  localparam int M_FAST  = 0;
  localparam int M_SLOW  = 1;
  localparam int M_BOTH  = 2;
  localparam int M_NONE  = 3;
  localparam int M_DCO   = 4;
  localparam int M_NOISE = 5;

  localparam int S_IDLE   = 0;
  localparam int S_COARSE = 1;
  localparam int S_FINE   = 2;
  localparam int S_LOCKED = 3;

  logic              ref_clk = 1'b0;
  logic              rst     = 1'b1;
  logic              start   = 1'b0;
  logic              fast    = 1'b0;
  logic              slow    = 1'b0;
  logic [CODE_W-1:0] dco_code;
  logic              pfd_clr;
  logic              busy;
  logic              locked;
  logic              sat;

  int n_checks = 0;
  int n_pass   = 0;

  int m_state, m_code, m_step, m_ib, m_oob, m_locked, m_sat, m_busy;
  int dco_target = 'h5A;

  pfd_tune_ctrl #(
    .CODE_W     (CODE_W),
    .WIN        (WIN),
    .SETTLE     (SETTLE),
    .TOL        (TOL),
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_CNT (UNLOCK_CNT)
  ) dut (
    .ref_clk  (ref_clk),
    .rst      (rst),
    .start    (start),
    .fast     (fast),
    .slow     (slow),
    .dco_code (dco_code),
    .pfd_clr  (pfd_clr),
    .busy     (busy),
    .locked   (locked),
    .sat      (sat)
  );

  always #5 ref_clk = ~ref_clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge ref_clk);
    #1;
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_code = 1 << (CODE_W - 1); m_step = 1 << (CODE_W - 2);
    m_ib = 0; m_oob = 0; m_locked = 0; m_sat = 0; m_busy = 0;
  endtask

  task automatic model_fine_step(input int dir);
    int tgt;
    tgt = m_code + dir;
    if (tgt < 0 || tgt > CODE_MAX) m_sat = 1;
    else begin m_code = tgt; m_sat = 0; end
  endtask

  task automatic model_window(input int fc, input int sc);
    int dir;
    dir = (fc > sc + TOL) ? -1 : (sc > fc + TOL) ? 1 : 0;
    case (m_state)
      S_COARSE: begin
        if (dir == 0) m_state = S_FINE;
        else begin
          m_code = m_code + dir * m_step;
          if (m_step == 1) m_state = S_FINE;
          m_step = m_step / 2;
        end
      end
      S_FINE: begin
        if (dir == 0) begin
          m_sat = 0;
          m_ib++;
          if (m_ib == LOCK_CNT) begin m_state = S_LOCKED; m_locked = 1; m_oob = 0; end
        end else begin
          model_fine_step(dir);
          m_ib = 0;
        end
      end
      S_LOCKED: begin
        if (dir == 0) m_oob = 0;
        else begin
          m_oob++;
          if (m_oob == UNLOCK_CNT) begin
            m_state = S_FINE; m_locked = 0; m_ib = 0;
            model_fine_step(dir);
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_code"},   int'(dco_code), m_code);
    check({tag, "_locked"}, int'(locked),   m_locked);
    check({tag, "_sat"},    int'(sat),      m_sat);
    check({tag, "_busy"},   int'(busy),     m_busy);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) cyc();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    if (m_state == S_IDLE) begin
      m_state = S_COARSE; m_code = 1 << (CODE_W - 1); m_step = 1 << (CODE_W - 2);
      m_sat = 0; m_busy = 1; m_ib = 0; m_oob = 0;
    end
  endtask

  // one full window; inputs driven in cycles SETTLE-2..PER-3 reach the counters through the synchronizer
  task automatic run_window(input int mode, input int start_at);
    int   fc, sc;
    logic f, s;
    fc = 0; sc = 0;
    for (int p = 0; p < PER; p++) begin
      case (mode)
        M_FAST:  begin f = 1'b1; s = 1'b0; end
        M_SLOW:  begin f = 1'b0; s = 1'b1; end
        M_BOTH:  begin f = 1'b1; s = 1'b1; end
        M_NONE:  begin f = 1'b0; s = 1'b0; end
        M_DCO:   begin f = (m_code > dco_target); s = (m_code < dco_target); end
        default: begin f = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1)); end
      endcase
      fast = f;
      slow = s;
      if (p >= SETTLE - 2 && p <= PER - 3) begin
        if (f && !s) fc++;
        if (s && !f) sc++;
      end
      if (p == 0)      check("pfd_clr_settle",  int'(pfd_clr), 1);
      if (p == SETTLE) check("pfd_clr_measure", int'(pfd_clr), 0);
      if (p == start_at) start = 1'b1;
      cyc();
      start = 1'b0;
    end
    model_window(fc, sc);
    check_outputs("win");
  endtask

  int sat_codes[7]    = '{'hC0, 'hE0, 'hF0, 'hF8, 'hFC, 'hFE, 'hFF};
  int search_codes[7] = '{'h40, 'h60, 'h50, 'h58, 'h5C, 'h5A, 'h5A};

  initial begin
    model_reset();
    // reset state and quiescence without start
    do_reset(3);
    check("rst_code", int'(dco_code), 'h80);
    check("rst_busy", int'(busy), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_pfd_clr", int'(pfd_clr), 0);
    check("rst_sat", int'(sat), 0);
    for (int i = 0; i < 20; i++) begin
      fast = 1'($urandom_range(0, 1));
      slow = 1'($urandom_range(0, 1));
      cyc();
    end
    check("idle_code", int'(dco_code), 'h80);
    check("idle_busy", int'(busy), 0);
    check("idle_pfd_clr", int'(pfd_clr), 0);

    // permanently slow: climb to the top and saturate
    do_start();
    for (int i = 0; i < 7; i++) begin
      run_window(M_SLOW, -1);
      check("sat_climb_code", int'(dco_code), sat_codes[i]);
    end
    run_window(M_SLOW, -1);
    check("sat_top_code", int'(dco_code), 'hFF);
    check("sat_top_flag", int'(sat), 1);
    check("sat_top_locked", int'(locked), 0);

    // DCO model converging on 0x5A, then lock
    do_reset(1);
    dco_target = 'h5A;
    do_start();
    for (int i = 0; i < 11; i++) begin
      run_window(M_DCO, -1);
      if (i < 7)  check("search_code", int'(dco_code), search_codes[i]);
      if (i == 9) check("prelock_locked", int'(locked), 0);
    end
    check("lock_locked", int'(locked), 1);

    // single out-of-band window is tolerated, two drop lock
    run_window(M_FAST, -1);
    run_window(M_DCO, -1);
    check("oob1_locked", int'(locked), 1);
    check("oob1_code", int'(dco_code), 'h5A);
    run_window(M_FAST, -1);
    check("oob2a_locked", int'(locked), 1);
    run_window(M_FAST, -1);
    check("unlock_locked", int'(locked), 0);
    check("unlock_code", int'(dco_code), 'h59);

    // start while busy is ignored; both-high window is in-band
    run_window(M_BOTH, 10);
    check("both_code", int'(dco_code), 'h59);
    check("both_busy", int'(busy), 1);

    // reset in the middle of a coarse measurement
    do_reset(1);
    do_start();
    run_window(M_DCO, -1);
    for (int i = 0; i < 20; i++) cyc();
    rst = 1'b1;
    cyc();
    check("midrst_code", int'(dco_code), 'h80);
    check("midrst_busy", int'(busy), 0);
    check("midrst_pfd_clr", int'(pfd_clr), 0);
    check("midrst_locked", int'(locked), 0);
    rst = 1'b0;
    model_reset();
    do_start();
    run_window(M_DCO, -1);
    check("restart_code", int'(dco_code), 'h40);

    // randomized windows with occasional restart toward a fresh target
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        do_reset(1 + $urandom_range(0, 2));
        dco_target = $urandom_range(0, CODE_MAX);
        do_start();
      end
      run_window($urandom_range(0, 5), ($urandom_range(0, 3) == 0) ? $urandom_range(0, PER - 1) : -1);
    end
    do_reset(1);
    dco_target = $urandom_range(0, CODE_MAX);
    do_start();
    for (int i = 0; i < 14; i++) run_window(M_DCO, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
